// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer: feeds NBYTES-wide operands LSB byte first through an
// external combinational 8-bit ripple-carry adder and collects the sum.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand handshake (in_a, in_b, in_cin)
//   rca_a/rca_b/rca_cin       byte slice and carry driven to the adder
//   rca_sum/rca_cout          adder result for the current slice
//   out_valid/out_ready       result handshake (out_sum, out_cout, out_ovf)
//   busy                      transaction in progress (ADD or DONE)

module rca_word_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    input  logic                  in_cin,
    output logic [7:0]            rca_a,
    output logic [7:0]            rca_b,
    output logic                  rca_cin,
    input  logic [7:0]            rca_sum,
    input  logic                  rca_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry_reg;
    logic [IW-1:0] idx;
    logic [IW+2:0] ofs;
    logic          cout_reg;
    logic          ovf_reg;
    logic          last;
    logic          accept;

    // Bit offset of the current byte slice.
    assign ofs    = {idx, 3'b000};
    assign last   = (idx == LAST);
    assign accept = in_valid && in_ready;

    assign out_sum  = sum_reg;
    assign out_cout = cout_reg;
    assign out_ovf  = ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rca_a     = 8'h00;
        rca_b     = 8'h00;
        rca_cin   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy    = 1'b1;
                rca_a   = a_reg[ofs +: 8];
                rca_b   = b_reg[ofs +: 8];
                rca_cin = carry_reg;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        idx       <= '0;
                    end
                end
                ADD: begin
                    sum_reg[ofs +: 8] <= rca_sum;
                    carry_reg         <= rca_cout;
                    if (last) begin
                        // Signed overflow: like-signed operands, result
                        // sign differs from them.
                        cout_reg <= rca_cout;
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1])
                                 && (rca_sum[7] != a_reg[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_word_sequencer.sv
// tb_rca_word_sequencer: directed-vector bench for rca_word_sequencer with
// a behavioural 8-bit ripple-carry adder on the rca_* ports.

module tb_rca_word_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [7:0]   rca_a;
    logic [7:0]   rca_b;
    logic         rca_cin;
    logic [7:0]   rca_sum;
    logic         rca_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int n_chk;
    int n_err;

    rca_word_sequencer #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .rca_a     (rca_a),
        .rca_b     (rca_b),
        .rca_cin   (rca_cin),
        .rca_sum   (rca_sum),
        .rca_cout  (rca_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // External combinational adder.
    assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b}
                               + {8'h00, rca_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] es,
                       input logic ec, input logic eo,
                       input logic [3:0] ecins, input int hold);
        logic [W:0] m;
        logic [3:0] cins;
        int         lat;
        int         w;
        m    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        cins = '0;
        w    = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        step();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_cin   = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            if (lat <= NB) cins[lat-1] = rca_cin;
            step();
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(NB + 1));
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".sum"}, 64'(out_sum), 64'(es));
        chk({tag, ".cout"}, 64'(out_cout), 64'(ec));
        chk({tag, ".ovf"}, 64'(out_ovf), 64'(eo));
        chk({tag, ".model"}, 64'({out_cout, out_sum}), 64'(m));
        chk({tag, ".cins"}, 64'(cins), 64'(ecins));
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a      = 32'hDEAD_BEEF;
            in_b      = 32'h1234_5678;
            for (int h = 0; h < hold; h++) begin
                step();
                chk({tag, ".hold_v"}, 64'(out_valid), 64'd1);
                chk({tag, ".hold_r"}, 64'(in_ready), 64'd0);
                chk({tag, ".hold_s"},
                    64'({out_ovf, out_cout, out_sum}),
                    64'({eo, ec, es}));
            end
            in_valid = 1'b0;
            in_a     = '0;
            in_b     = '0;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".post_r"}, 64'(in_ready), 64'd1);
        chk({tag, ".post_v"}, 64'(out_valid), 64'd0);
        chk({tag, ".post_s"}, 64'(out_sum), 64'(es));
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_sum", 64'(out_sum), 64'd0);
        chk("rst.flags", 64'({out_cout, out_ovf, busy}), 64'd0);
        chk("rst.rca", 64'({rca_a, rca_b, rca_cin}), 64'd0);
        rst = 1'b0;
        step();
        chk("rel.in_ready", 64'(in_ready), 64'd1);

        run("t1", 32'h0000_0005, 32'h0000_0003, 1'b0,
            32'h0000_0008, 1'b0, 1'b0, 4'b0000, 0);
        run("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0,
            32'h0000_0000, 1'b1, 1'b0, 4'b1110, 0);
        run("t3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
            32'hFFFF_FFFF, 1'b1, 1'b0, 4'b1111, 0);
        run("t4", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
            32'h8000_0000, 1'b0, 1'b1, 4'b1110, 0);
        run("t5", 32'h0000_00C0, 32'h0000_0040, 1'b0,
            32'h0000_0100, 1'b0, 1'b0, 4'b0010, 0);
        run("bp", 32'h1234_5678, 32'h1111_1111, 1'b0,
            32'h2345_6789, 1'b0, 1'b0, 4'b0000, 3);
        run("t6", 32'h8000_0000, 32'h8000_0000, 1'b0,
            32'h0000_0000, 1'b1, 1'b1, 4'b0000, 0);

        // Abort mid-ADD with a one-cycle reset.
        in_valid = 1'b1;
        in_a     = 32'h0102_0304;
        in_b     = 32'h0506_0708;
        step();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        step();
        chk("ab.busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        chk("ab.out_valid", 64'(out_valid), 64'd0);
        chk("ab.out_sum", 64'(out_sum), 64'd0);
        chk("ab.flags", 64'({out_cout, out_ovf, busy}), 64'd0);
        chk("ab.rca", 64'({rca_a, rca_b, rca_cin}), 64'd0);
        chk("ab.in_ready", 64'(in_ready), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ab.no_valid", 64'(out_valid), 64'd0);
        end
        out_ready = 1'b0;
        run("t7", 32'd120, 32'd56, 1'b0,
            32'h0000_00B0, 1'b0, 1'b0, 4'b0000, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
